// File: rtl/cw_decoder_top_if.sv
// Codeword-in / message-byte-out bus of the constant-weight decoder.
interface cw_decoder_top_if #(
   parameter int unsigned N = 18
);
   logic         start;
   logic [N-1:0] cw_in;
   logic         cw_valid;
   logic         cw_ready;
   logic [7:0]   msg_byte;
   logic         byte_valid;
   logic         byte_ready;
   logic         busy;
   logic         done;
   logic         err;

   // Source / sink side (drives codewords, accepts bytes)
   modport master (
      output start, cw_in, cw_valid, byte_ready,
      input  cw_ready, msg_byte, byte_valid, busy, done, err
   );

   // Decoder side
   modport slave (
      input  start, cw_in, cw_valid, byte_ready,
      output cw_ready, msg_byte, byte_valid, busy, done, err
   );
endinterface

// File: rtl/cw_decoder_top.sv
// 18-choose-9 constant-weight decoder: ranks each codeword to a 15-bit
// index, serialises it MSB-first and packs the stream into message bytes.
module cw_decoder_top #(
   parameter int unsigned N      = 18,
   parameter int unsigned W      = 9,
   parameter int unsigned K      = 15,
   parameter int unsigned NUM_CW = 10
) (
   input logic            clk,
   input logic            rst,
   cw_decoder_top_if.slave bus
);

   localparam int unsigned RW    = 16;
   localparam int unsigned PW    = $clog2(N);
   localparam int unsigned PCW   = $clog2(N + 1);
   localparam int unsigned WW    = $clog2(W + 1);
   localparam int unsigned CNW   = $clog2(NUM_CW + 1);
   localparam int unsigned BCW   = $clog2(K + 1);
   localparam int unsigned TBITS = N * (W + 1) * RW;
   localparam int unsigned TW    = $clog2(TBITS);

   // Binomial table C(i,w), i<N, w<=W, flattened row-major, RW bits per entry
   function automatic logic [TBITS-1:0] build_tbl();
      logic [TBITS-1:0] t;
      int unsigned      c;
      t = '0;
      for (int unsigned i = 0; i < N; i++) begin
         c = 1;
         for (int unsigned w = 0; w <= W; w++) begin
            t[(i * (W + 1) + w) * RW +: RW] = RW'(c);
            c = (w < i) ? (c * (i - w)) / (w + 1) : 0;
         end
      end
      return t;
   endfunction

   localparam logic [TBITS-1:0] TBL = build_tbl();

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT, S_RANK, S_CHECK, S_SHIFT, S_FLUSH, S_DONE
   } state_t;

   state_t          state;
   logic [N-1:0]    cw_reg;
   logic [RW-1:0]   rank;
   logic [WW-1:0]   w_left;
   logic [PW-1:0]   pos;
   logic [PCW-1:0]  pop;
   logic [K-1:0]    idx_sr;
   logic [BCW-1:0]  bit_cnt;
   logic [CNW-1:0]  cw_cnt;
   logic [3:0]      pk_cnt;

   logic [TW-1:0]   tbl_base;
   logic [RW-1:0]   c_val;
   logic            cur_bit;
   logic            bit_in;
   logic            accept;
   logic            shift_en;

   // Table lookup for the current position / remaining weight
   assign tbl_base = (TW'(pos) * TW'(W + 1) + TW'(w_left)) * TW'(RW);
   assign c_val    = TBL[tbl_base +: RW];
   assign cur_bit  = cw_reg[pos];
   assign bit_in   = idx_sr[K-1];

   // A full byte leaves when taken; a new bit may enter in that same cycle
   assign accept   = bus.byte_valid & bus.byte_ready;
   assign shift_en = (state == S_SHIFT) & (~bus.byte_valid | bus.byte_ready);

   // Control FSM, ranking datapath and byte packer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= S_IDLE;
         cw_reg         <= '0;
         rank           <= '0;
         w_left         <= '0;
         pos            <= '0;
         pop            <= '0;
         idx_sr         <= '0;
         bit_cnt        <= '0;
         cw_cnt         <= '0;
         pk_cnt         <= '0;
         bus.cw_ready   <= 1'b0;
         bus.msg_byte   <= '0;
         bus.byte_valid <= 1'b0;
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
         bus.err        <= 1'b0;
      end else begin
         bus.done <= 1'b0;

         // Packer: bit k of a byte lands at position 7-k, so the unfilled
         // low bits are already zero when a partial byte is flushed
         if (accept) begin
            bus.byte_valid <= 1'b0;
            if (shift_en) begin
               bus.msg_byte <= {bit_in, 7'b0};
               pk_cnt       <= 4'd1;
            end else begin
               bus.msg_byte <= '0;
               pk_cnt       <= 4'd0;
            end
         end else if (shift_en) begin
            bus.msg_byte <= bus.msg_byte | ({bit_in, 7'b0} >> pk_cnt);
            pk_cnt       <= pk_cnt + 4'd1;
            if (pk_cnt == 4'd7) bus.byte_valid <= 1'b1;
         end else if (state == S_FLUSH && !bus.byte_valid && pk_cnt != 4'd0) begin
            bus.byte_valid <= 1'b1;
            pk_cnt         <= 4'd8;
         end

         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  state        <= S_WAIT;
                  bus.err      <= 1'b0;
                  cw_cnt       <= '0;
                  bus.cw_ready <= 1'b1;
                  bus.busy     <= 1'b1;
               end
            end

            S_WAIT: begin
               if (bus.cw_valid) begin
                  cw_reg       <= bus.cw_in;
                  rank         <= '0;
                  w_left       <= WW'(W);
                  pos          <= PW'(N - 1);
                  pop          <= '0;
                  state        <= S_RANK;
                  bus.cw_ready <= 1'b0;
               end
            end

            S_RANK: begin
               if (cur_bit) begin
                  pop <= pop + PCW'(1);
                  if (w_left != '0) begin
                     rank   <= rank + c_val;
                     w_left <= w_left - WW'(1);
                  end
               end
               if (pos == '0) state <= S_CHECK;
               else           pos   <= pos - PW'(1);
            end

            S_CHECK: begin
               // Bad codewords still emit K zero bits to keep byte alignment
               if (pop != PCW'(W) || rank >= RW'(1 << K)) begin
                  bus.err <= 1'b1;
                  idx_sr  <= '0;
               end else begin
                  idx_sr  <= rank[K-1:0];
               end
               bit_cnt <= '0;
               state   <= S_SHIFT;
            end

            S_SHIFT: begin
               if (shift_en) begin
                  idx_sr  <= {idx_sr[K-2:0], 1'b0};
                  bit_cnt <= bit_cnt + BCW'(1);
                  if (bit_cnt == BCW'(K - 1)) begin
                     cw_cnt <= cw_cnt + CNW'(1);
                     if (cw_cnt == CNW'(NUM_CW - 1)) begin
                        state <= S_FLUSH;
                     end else begin
                        state        <= S_WAIT;
                        bus.cw_ready <= 1'b1;
                     end
                  end
               end
            end

            S_FLUSH: begin
               if (!bus.byte_valid && pk_cnt == 4'd0) begin
                  state    <= S_DONE;
                  bus.done <= 1'b1;
               end
            end

            S_DONE: begin
               if (bus.start) begin
                  state        <= S_WAIT;
                  bus.err      <= 1'b0;
                  cw_cnt       <= '0;
                  bus.cw_ready <= 1'b1;
               end else begin
                  state    <= S_IDLE;
                  bus.busy <= 1'b0;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cw_decoder_top.sv
// Randomised bench for cw_decoder_top against a combinatorial rank model.
module tb_cw_decoder_top;

   localparam int NUM_CW = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;

   cw_decoder_top_if bus ();

   cw_decoder_top dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [17:0] blk [NUM_CW];
   logic [7:0]  exp_q [$];
   logic [7:0]  rx_q  [$];
   logic        exp_err;

   int   ready_mode = 0;     // 0: always ready, 1: random ready
   bit   stall_req  = 0;
   bit   stall_seen = 0;
   int   stall_left = 0;
   int   done_cnt   = 0;
   bit   prev_pending = 0;
   logic [7:0] prev_byte = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int unsigned binom(input int unsigned n, input int unsigned k);
      longint unsigned r;
      if (k > n) return 0;
      r = 1;
      for (int unsigned j = 0; j < k; j++) r = r * (n - j) / (j + 1);
      return 32'(r);
   endfunction

   // Rank = sum over the t-th one from the top (t=1..9) at position p of C(p, 10-t)
   function automatic int unsigned cw_rank(input logic [17:0] cw);
      int unsigned r, seen;
      r = 0; seen = 0;
      for (int p = 17; p >= 0; p--) begin
         if (cw[p]) begin
            seen++;
            if (seen <= 9) r += binom(p, 10 - seen);
         end
      end
      return r;
   endfunction

   task automatic build_expected();
      bit          b [$];
      int unsigned rk;
      logic [14:0] idx;
      logic [7:0]  v;
      bit          ok;
      exp_q.delete();
      exp_err = 1'b0;
      for (int i = 0; i < NUM_CW; i++) begin
         rk  = cw_rank(blk[i]);
         ok  = ($countones(blk[i]) == 9) && (rk < 32768);
         if (!ok) exp_err = 1'b1;
         idx = ok ? 15'(rk) : 15'd0;
         for (int j = 14; j >= 0; j--) b.push_back(idx[j]);
      end
      for (int s = 0; s < b.size(); s += 8) begin
         v = '0;
         for (int t = 0; t < 8; t++) if (s + t < b.size()) v[7-t] = b[s+t];
         exp_q.push_back(v);
      end
   endtask

   function automatic logic [17:0] rand_valid_cw();
      logic [17:0] c;
      c = '0;
      while ($countones(c) < 9) c[$urandom_range(0, 17)] = 1'b1;
      return c;
   endfunction

   // Sink: drives byte_ready, captures accepted bytes, checks hold-stability
   always @(negedge clk) begin
      logic r;
      if (rst) begin
         prev_pending = 0;
         stall_left   = 0;
         bus.byte_ready = 1'b0;
      end else begin
         if (prev_pending) begin
            check("hold_valid", bus.byte_valid, 1'b1);
            check("hold_byte", bus.msg_byte, prev_byte);
         end
         if (stall_left > 0) begin
            r = 1'b0;
            stall_left--;
            check("stall_cw_ready", bus.cw_ready, 1'b0);
         end else if (stall_req && bus.byte_valid) begin
            stall_req  = 0;
            stall_seen = 1;
            stall_left = 19;
            r = 1'b0;
         end else if (ready_mode == 0) begin
            r = 1'b1;
         end else begin
            r = ($urandom_range(0, 3) != 0);
         end
         bus.byte_ready = r;
         if (bus.byte_valid && r) rx_q.push_back(bus.msg_byte);
         prev_pending = bus.byte_valid && !r;
         prev_byte    = bus.msg_byte;
         if (bus.done) begin
            done_cnt++;
            check("bytes_at_done", rx_q.size(), exp_q.size());
         end
      end
   end

   // Called at a negedge; returns at the negedge after the handshake
   task automatic send_cw(input logic [17:0] cw);
      int n;
      n = 0;
      bus.cw_in    = cw;
      bus.cw_valid = 1'b1;
      while (!bus.cw_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (!bus.cw_ready) check("cw_handshake_timeout", 0, 1);
      @(negedge clk);
      bus.cw_valid = 1'b0;
   endtask

   task automatic start_block();
      rx_q.delete();
      done_cnt = 0;
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("busy_after_start", bus.busy, 1'b1);
      check("err_after_start", bus.err, 1'b0);
      check("cw_ready_after_start", bus.cw_ready, 1'b1);
   endtask

   task automatic run_block();
      int n;
      build_expected();
      start_block();
      for (int i = 0; i < NUM_CW; i++) send_cw(blk[i]);
      n = 0;
      while (done_cnt == 0 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("done_seen", 32'(done_cnt > 0), 1);
      repeat (4) @(negedge clk);
      check("done_pulses", done_cnt, 1);
      check("busy_end", bus.busy, 1'b0);
      check("err_end", bus.err, exp_err);
      check("byte_count", rx_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         check($sformatf("byte%0d", i), (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hDEAD, exp_q[i]);
   endtask

   initial begin
      bus.start      = 1'b0;
      bus.cw_in      = '0;
      bus.cw_valid   = 1'b0;
      bus.byte_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_cw_ready", bus.cw_ready, 1'b0);
      check("rst_byte_valid", bus.byte_valid, 1'b0);
      check("rst_msg_byte", bus.msg_byte, 8'h00);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_done", bus.done, 1'b0);
      check("rst_err", bus.err, 1'b0);

      // All-rank-0 block: 19 zero bytes
      for (int i = 0; i < NUM_CW; i++) blk[i] = 18'h001FF;
      run_block();
      check("blk0_nbytes", rx_q.size(), 19);

      // Rank 9 then rank 0
      blk[0] = 18'h003FE;
      blk[1] = 18'h001FF;
      for (int i = 2; i < NUM_CW; i++) blk[i] = rand_valid_cw();
      run_block();
      check("rank9_byte0", (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'hDEAD, 8'h00);
      check("rank9_byte1", (rx_q.size() > 1) ? 32'(rx_q[1]) : 32'hDEAD, 8'h12);

      // Rank out of range
      blk[0] = 18'h3FE00;
      for (int i = 1; i < NUM_CW; i++) blk[i] = rand_valid_cw();
      run_block();
      check("overrange_err", bus.err, 1'b1);

      // Weight 8 with random sink back-pressure
      ready_mode = 1;
      blk[0] = 18'h000FF;
      for (int i = 1; i < NUM_CW; i++) blk[i] = rand_valid_cw();
      run_block();
      check("weight8_err", bus.err, 1'b1);

      // 20-cycle stall on the first byte
      ready_mode = 0;
      stall_req  = 1;
      stall_seen = 0;
      for (int i = 0; i < NUM_CW; i++) blk[i] = rand_valid_cw();
      run_block();
      check("stall_seen", 32'(stall_seen), 1);

      // Reset during ranking of the 4th codeword, then a clean block
      for (int i = 0; i < NUM_CW; i++) blk[i] = rand_valid_cw();
      build_expected();
      start_block();
      for (int i = 0; i < 4; i++) send_cw(blk[i]);
      repeat (3) @(negedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("mid_rst_cw_ready", bus.cw_ready, 1'b0);
      check("mid_rst_byte_valid", bus.byte_valid, 1'b0);
      check("mid_rst_msg_byte", bus.msg_byte, 8'h00);
      check("mid_rst_busy", bus.busy, 1'b0);
      check("mid_rst_err", bus.err, 1'b0);
      #1 rst = 1'b0;
      repeat (60) @(negedge clk);
      check("mid_rst_no_done", done_cnt, 0);
      check("mid_rst_idle", bus.busy, 1'b0);
      run_block();

      // Random mixed blocks with random back-pressure
      ready_mode = 1;
      for (int b = 0; b < 4; b++) begin
         for (int i = 0; i < NUM_CW; i++)
            blk[i] = ($urandom_range(0, 4) == 0) ? 18'($urandom) : rand_valid_cw();
         run_block();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cw_decoder_top.md
Name: cw_decoder_top

Overview:
- Receiver-side counterpart of the 18-9 constant-weight encoder path.
- Accepts 18-bit constant-weight codewords, ranks each one back to its 15-bit message index by enumerative decoding, and serialises the index MSB-first.
- Packs the resulting bit stream into message bytes with a valid/ready output.
- After NUM_CW codewords, flushes any partial byte and pulses done.

Parameters:
- N, 18, codeword length in bits.
- W, 9, codeword weight.
- K, 15, message bits per codeword.
- NUM_CW, 10, codewords per message block.
- Only the defaults are verified.

Ports:
- clk  in  1  single clock, all flops rising-edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse; begins a block, clears err and done. Ignored unless idle or done.
- cw_in  in  18  codeword; bit i is position i.
- cw_valid  in  1  cw_in valid.
- cw_ready  out  1  decoder can accept a codeword this cycle.
- msg_byte  out  8  packed message byte; first decoded bit lands in bit 7.
- byte_valid  out  1  msg_byte valid.
- byte_ready  in  1  downstream accepts msg_byte.
- busy  out  1  block in progress.
- done  out  1  one-cycle pulse after the final byte is accepted.
- err  out  1  sticky; set on any invalid codeword.

Behaviour:
- Reset: all outputs 0, state IDLE, internal counters and registers 0, packer empty.
  - Reset mid-block abandons the block; no done pulse is produced.
- State IDLE: cw_ready=0. On start go to WAIT, clear err, clear codeword count.
- State WAIT: cw_ready=1.
  - Codeword handshake occurs when cw_valid and cw_ready are both high.
  - On handshake, latch cw_in, set rank=0, w=W, i=N-1, popcount=0, go to RANK.
- State RANK: one position per cycle, i from 17 down to 0, N=18 cycles.
  - If bit i=1 and w>0: rank += C(i,w), w--.
  - popcount counts all ones seen.
  - C(i,w) comes from a constant table, i<18, w<=9; max value 24310, 16 bits.
  - rank register is 16 bits wide.
- State CHECK: one cycle.
  - Codeword is invalid if popcount != W, or if rank >= 2^K (32768); max rank is 48619.
  - Invalid: set err, replace the index with 0 (keeps byte alignment).
  - Load the 15-bit index into the shift register, go to SHIFT.
- State SHIFT: one bit per cycle, MSB first, into the packer.
  - When the packer holds 8 bits it presents byte_valid=1.
  - Shifting stalls while byte_valid=1 and byte_ready=0.
  - A bit may enter the packer in the same cycle the full byte is accepted (no bubble).
  - After 15 bits, increment the codeword count.
    - count < NUM_CW: go to WAIT.
    - count = NUM_CW: go to FLUSH.
- Latency: an unstalled codeword takes 1+18+1+15 = 35 cycles from handshake to the last bit packed.
- State FLUSH: if the packer holds 1..7 bits, pad the low bits with 0 and present the byte.
  - Wait for the byte handshake and for any pending full byte.
  - Default block: 150 bits, giving 19 bytes with the last byte padded by 2 zero bits.
- State DONE: pulse done for 1 cycle, drop busy, return to IDLE.
- busy is high in every state except IDLE.
- msg_byte and byte_valid stay stable while byte_valid=1 and byte_ready=0.
- byte_valid may assert with no dependence on byte_ready.
- cw_valid while cw_ready=0 is ignored; the source must hold it.
- start during WAIT/RANK/CHECK/SHIFT/FLUSH is ignored.

Test Plan:
- Block of 10× cw_in=18'h001FF (ones at positions 0..8, rank 0), byte_ready=1 -> 19 bytes of 0x00, err=0, single done pulse after byte 19.
- cw1=18'h003FE (rank 9, bits 000000000001001), then cw2=18'h001FF -> byte0=0x00, byte1=0x12, err=0.
- cw=18'h3FE00 (rank 48619 >= 32768) -> err=1 sticky, 15 zero bits emitted; next start clears err.
- cw=18'h000FF (weight 8) -> err=1, zero bits emitted; subsequent valid codewords decode normally.
- byte_ready held low 20 cycles while byte_valid=1 -> msg_byte stable, shifting stalled, cw_ready stays 0; on release the stream resumes with no lost or duplicated bits versus the unstalled run.
- rst pulsed during RANK of codeword 4 -> all outputs 0 next cycle, no done; new start yields a correct full block.
